uart_rx_cfg: RTL and testbench

//  Parametrised next-generation UART receiver: oversampled serial-to-parallel conversion

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_sampler.sv | 49 ++++
 rtl/uart_rx_cfg.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver.
// Holds the receive FSM state encoding, parity-type codes, legal ranges and the vote helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int DATA_WIDTH_MIN = 5;
    localparam int DATA_WIDTH_MAX = 9;
    localparam int PRESCALE_MIN   = 8;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and 3-sample majority vote around the bit centre.
// bit_done/bit_val strobe the voted value; bit_end marks the last clock of a bit period.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  active,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  rx_s,
    output logic                  bit_done,
    output logic                  bit_val,
    output logic                  bit_end
);

    logic [PRESCALE_W-1:0] edge_cnt;
    logic [PRESCALE_W-1:0] half;
    logic                  s0;
    logic                  s1;

    assign half = prescale >> 1;

    // Held at 1 while idle: the cycle that detects the start edge is edge 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt <= PRESCALE_W'(1);
            s0       <= 1'b1;
            s1       <= 1'b1;
        end else begin
            if (!active)
                edge_cnt <= PRESCALE_W'(1);
            else if (bit_end)
                edge_cnt <= '0;
            else
                edge_cnt <= edge_cnt + 1'b1;
            if (active && edge_cnt == half - 1'b1)
                s0 <= rx_s;
            if (active && edge_cnt == half)
                s1 <= rx_s;
        end
    end

    assign bit_end  = active && (edge_cnt == prescale - 1'b1);
    assign bit_done = active && (edge_cnt == half + 1'b1);
    assign bit_val  = majority3(s0, s1, rx_s);

endmodule

// File: rtl/uart_rx_cfg.sv
// Oversampled UART receiver with runtime parity / stop-bit selection and error pulses.
// Frame control, shift register, parity check and result pulses live here; timing in the sampler.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int PRESCALE_W  = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_type,
    input  logic                  stop2_en,
    output logic                  data_valid,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    rx_state_t             state;
    rx_state_t             next_state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                  rx_s;
    logic [PRESCALE_W-1:0] presc_q;
    logic                  par_en_q;
    logic                  par_type_q;
    logic                  stop2_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  stop_err_q;
    logic                  par_mis_q;
    logic                  second_stop_q;
    logic                  rearm_q;
    logic                  start_det;
    logic                  par_expect;
    logic                  bit_done;
    logic                  bit_val;
    logic                  bit_end;
    logic                  final_vote;
    logic                  fire_stp;
    logic                  fire_par;
    logic                  fire_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sync_q <= '1;
        else
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
    end

    assign rx_s       = sync_q[SYNC_STAGES-1];
    assign start_det  = (state == IDLE) && !rx_s && !rearm_q;
    assign par_expect = (par_type_q == PAR_ODD) ? ~^shift_q : ^shift_q;

    uart_rx_sampler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_sampler (
        .clk      (clk),
        .rst      (rst),
        .active   (state != IDLE),
        .prescale (presc_q),
        .rx_s     (rx_s),
        .bit_done (bit_done),
        .bit_val  (bit_val),
        .bit_end  (bit_end)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (start_det) next_state = START;
            START: begin
                if (bit_done && bit_val)
                    next_state = IDLE;
                else if (bit_end)
                    next_state = DATA;
            end
            DATA:   if (bit_end && bit_cnt == CNT_W'(DATA_WIDTH))
                        next_state = par_en_q ? PARITY : STOP;
            PARITY: if (bit_end) next_state = STOP;
            STOP:   if (bit_done && (!stop2_q || second_stop_q)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Stop errors take priority over parity; only one result pulse per frame.
    always_comb begin
        final_vote = (state == STOP) && bit_done && (!stop2_q || second_stop_q);
        fire_stp   = final_vote && (stop_err_q || !bit_val);
        fire_par   = final_vote && !fire_stp && par_mis_q;
        fire_valid = final_vote && !fire_stp && !par_mis_q;
        busy       = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q       <= PRESCALE_W'(PRESCALE_MIN);
            par_en_q      <= 1'b0;
            par_type_q    <= PAR_EVEN;
            stop2_q       <= 1'b0;
            shift_q       <= '0;
            bit_cnt       <= '0;
            stop_err_q    <= 1'b0;
            par_mis_q     <= 1'b0;
            second_stop_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_det) begin
                    presc_q    <= prescale;
                    par_en_q   <= par_en;
                    par_type_q <= par_type;
                    stop2_q    <= stop2_en;
                end
                START: begin
                    bit_cnt       <= '0;
                    stop_err_q    <= 1'b0;
                    par_mis_q     <= 1'b0;
                    second_stop_q <= 1'b0;
                end
                DATA: if (bit_done) begin
                    shift_q <= {bit_val, shift_q[DATA_WIDTH-1:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                PARITY: if (bit_done) par_mis_q <= (bit_val != par_expect);
                STOP: if (bit_done) begin
                    if (!bit_val) stop_err_q <= 1'b1;
                    if (stop2_q) second_stop_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // After a stop error the line must return high before another start is accepted (break handling).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            p_data     <= '0;
            rearm_q    <= 1'b0;
        end else begin
            data_valid <= fire_valid;
            par_err    <= fire_par;
            stp_err    <= fire_stp;
            if (fire_valid)
                p_data <= shift_q;
            if (fire_stp)
                rearm_q <= 1'b1;
            else if (rx_s)
                rearm_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: 8-, 5- and 9-bit builds driven from one serial line model.
module tb_uart_rx_cfg;

    typedef struct {
        int         inst;
        logic [2:0] kind;
        logic [8:0] data;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       line;
    int         sel;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_type;
    logic       stop2_en;
    logic       rx8, rx5, rx9;
    logic       dv8, pe8, se8, busy8;
    logic       dv5, pe5, se5, busy5;
    logic       dv9, pe9, se9, busy9;
    logic [7:0] pd8;
    logic [4:0] pd5;
    logic [8:0] pd9;
    exp_t       sb[$];
    int         total;
    int         bad;

    assign rx8 = (sel == 8) ? line : 1'b1;
    assign rx5 = (sel == 5) ? line : 1'b1;
    assign rx9 = (sel == 9) ? line : 1'b1;

    uart_rx_cfg #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .rx_in(rx8), .prescale(prescale), .par_en(par_en),
        .par_type(par_type), .stop2_en(stop2_en), .data_valid(dv8), .p_data(pd8),
        .par_err(pe8), .stp_err(se8), .busy(busy8));

    uart_rx_cfg #(.DATA_WIDTH(5)) dut5 (
        .clk(clk), .rst(rst), .rx_in(rx5), .prescale(prescale), .par_en(par_en),
        .par_type(par_type), .stop2_en(stop2_en), .data_valid(dv5), .p_data(pd5),
        .par_err(pe5), .stp_err(se5), .busy(busy5));

    uart_rx_cfg #(.DATA_WIDTH(9)) dut9 (
        .clk(clk), .rst(rst), .rx_in(rx9), .prescale(prescale), .par_en(par_en),
        .par_type(par_type), .stop2_en(stop2_en), .data_valid(dv9), .p_data(pd9),
        .par_err(pe9), .stp_err(se9), .busy(busy9));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Any result pulse must match the oldest expected frame result.
    task automatic observe(input int inst, input logic dv, input logic pe, input logic se,
                           input logic [8:0] pd);
        exp_t e;
        if (dv | pe | se) begin
            if (sb.size() == 0) begin
                check_output($sformatf("unexpected_pulse_w%0d", inst), {29'b0, dv, pe, se}, 32'd0);
            end else begin
                e = sb.pop_front();
                check_output("pulse_inst", inst, e.inst);
                check_output($sformatf("pulse_kind_w%0d", inst), {29'b0, dv, pe, se}, {29'b0, e.kind});
                if (e.kind == 3'b100)
                    check_output($sformatf("p_data_w%0d", inst), {23'b0, pd}, {23'b0, e.data});
            end
        end
    endtask

    always @(negedge clk) begin
        observe(8, dv8, pe8, se8, {1'b0, pd8});
        observe(5, dv5, pe5, se5, {4'b0, pd5});
        observe(9, dv9, pe9, se9, pd9);
    end

    task automatic drive_bit(input logic v, input int presc, input bit spike);
        for (int c = 0; c < presc; c++) begin
            line = (spike && c == presc / 2) ? ~v : v;
            @(negedge clk);
        end
        line = v;
    endtask

    task automatic idle(input int n);
        line = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame on the selected instance and queues the result it must produce.
    task automatic apply_stimulus(input int inst, input int width, input logic [8:0] data,
                                  input int presc, input bit pen, input bit ptype, input bit flip,
                                  input bit s2, input bit stop1, input bit stop2v, input int spike_bit);
        logic [8:0] d;
        logic       p;
        exp_t       e;
        d        = data & ((9'h1 << width) - 9'h1);
        sel      = inst;
        prescale = presc[5:0];
        par_en   = pen;
        par_type = ptype;
        stop2_en = s2;
        p        = (^d) ^ ptype ^ flip;
        e.inst   = inst;
        e.data   = d;
        if (!stop1 || (s2 && !stop2v))
            e.kind = 3'b001;
        else if (pen && flip)
            e.kind = 3'b010;
        else
            e.kind = 3'b100;
        sb.push_back(e);
        drive_bit(1'b0, presc, 1'b0);
        for (int i = 0; i < width; i++)
            drive_bit(d[i], presc, i == spike_bit);
        if (pen)
            drive_bit(p, presc, 1'b0);
        drive_bit(stop1, presc, 1'b0);
        if (s2)
            drive_bit(stop2v, presc, 1'b0);
        line = 1'b1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400 && sb.size() != 0; i++)
            @(negedge clk);
        check_output({tag, "_drain"}, sb.size(), 32'd0);
        check_output({tag, "_idle"}, {29'b0, busy8, busy5, busy9}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int cnt;
        total    = 0;
        bad      = 0;
        rst      = 1'b0;
        line     = 1'b1;
        sel      = 8;
        prescale = 6'd8;
        par_en   = 1'b0;
        par_type = 1'b0;
        stop2_en = 1'b0;
        repeat (3) @(negedge clk);
        check_output("rst_w8", {20'b0, dv8, pe8, se8, busy8, pd8}, 32'd0);
        check_output("rst_w5", {23'b0, dv5, pe5, se5, busy5, pd5}, 32'd0);
        check_output("rst_w9", {19'b0, dv9, pe9, se9, busy9, pd9}, 32'd0);
        rst = 1'b1;
        idle(10);

        // Back-to-back 8N1 frames on every build
        apply_stimulus(8, 8, 9'h0A5, 8, 0, 0, 0, 0, 1, 1, -1);
        apply_stimulus(8, 8, 9'h03C, 8, 0, 0, 0, 0, 1, 1, -1);
        apply_stimulus(8, 8, 9'h0FF, 8, 0, 0, 0, 0, 1, 1, -1);
        drain("b2b_w8");
        apply_stimulus(5, 5, 9'h0A5, 8, 0, 0, 0, 0, 1, 1, -1);
        apply_stimulus(5, 5, 9'h03C, 8, 0, 0, 0, 0, 1, 1, -1);
        apply_stimulus(5, 5, 9'h0FF, 8, 0, 0, 0, 0, 1, 1, -1);
        drain("b2b_w5");
        apply_stimulus(9, 9, 9'h1A5, 8, 0, 0, 0, 0, 1, 1, -1);
        apply_stimulus(9, 9, 9'h03C, 8, 0, 0, 0, 0, 1, 1, -1);
        apply_stimulus(9, 9, 9'h1FF, 8, 0, 0, 0, 0, 1, 1, -1);
        drain("b2b_w9");

        // Parity, even and odd, good and flipped
        apply_stimulus(8, 8, 9'h096, 16, 1, 0, 0, 0, 1, 1, -1);
        apply_stimulus(8, 8, 9'h096, 16, 1, 0, 1, 0, 1, 1, -1);
        drain("par_even");
        check_output("par_hold_even", {24'b0, pd8}, 32'h96);
        apply_stimulus(8, 8, 9'h096, 32, 1, 1, 0, 0, 1, 1, -1);
        apply_stimulus(8, 8, 9'h05A, 32, 1, 1, 1, 0, 1, 1, -1);
        drain("par_odd");
        check_output("par_hold_odd", {24'b0, pd8}, 32'h96);

        // Two stop bits
        apply_stimulus(8, 8, 9'h0C3, 8, 0, 0, 0, 1, 1, 0, -1);
        idle(16);
        apply_stimulus(8, 8, 9'h0C3, 8, 0, 0, 0, 0, 1, 1, -1);
        apply_stimulus(8, 8, 9'h03C, 8, 0, 0, 0, 1, 1, 1, -1);
        drain("stop2");
        check_output("stop2_pdata", {24'b0, pd8}, 32'h3C);

        // Start glitch of two clocks
        sel      = 8;
        prescale = 6'd8;
        line     = 1'b0;
        repeat (2) @(negedge clk);
        line = 1'b1;
        for (int i = 0; i < 8 && !busy8; i++)
            @(negedge clk);
        check_output("glitch_start", {31'b0, busy8}, 32'd1);
        cnt = 0;
        while (busy8 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check_output("glitch_busy_drop", {31'b0, (cnt <= 6)}, 32'd1);
        idle(10);
        drain("glitch");

        // Single-clock spikes on the centre sample
        apply_stimulus(8, 8, 9'h055, 16, 0, 0, 0, 0, 1, 1, 2);
        apply_stimulus(8, 8, 9'h055, 16, 0, 0, 0, 0, 1, 1, 5);
        drain("spike");

        // Reset in the middle of the data bits
        sel      = 8;
        prescale = 6'd8;
        line     = 1'b0;
        repeat (8) @(negedge clk);
        line = 1'b1;
        repeat (8) @(negedge clk);
        line = 1'b0;
        repeat (8) @(negedge clk);
        check_output("mid_busy", {31'b0, busy8}, 32'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_output("mid_rst_out", {20'b0, dv8, pe8, se8, busy8, pd8}, 32'd0);
        line = 1'b1;
        rst  = 1'b1;
        idle(20);
        apply_stimulus(8, 8, 9'h081, 8, 0, 0, 0, 0, 1, 1, -1);
        drain("post_rst");
        check_output("post_rst_pdata", {24'b0, pd8}, 32'h81);

        // Break: line low for three frame times gives one stop error
        begin
            exp_t e;
            e.inst = 8;
            e.kind = 3'b001;
            e.data = 9'h0;
            sb.push_back(e);
        end
        line = 1'b0;
        repeat (240) @(negedge clk);
        idle(20);
        drain("break");
        apply_stimulus(8, 8, 9'h0E7, 8, 0, 0, 0, 0, 1, 1, -1);
        drain("after_break");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
